// File: rtl/keymap_rebind_writer_pkg.sv
// Shared constants and state encoding for the key-map rebind writer.
// Contents:
//   NOTE_KEY_BITS   - width of the note-key vector and of each stored one-hot mask
//   LENGTH_KEY_BITS - width of the note-length selector keys (used by the playback side)
//   rebind_state_e  - state encoding of the rebind controller
package keymap_rebind_writer_pkg;

  localparam int NOTE_KEY_BITS   = 7;
  localparam int LENGTH_KEY_BITS = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_REL  = 3'd1,
    ST_WAIT_KEY  = 3'd2,
    ST_WAIT_CONF = 3'd3,
    ST_WRITE     = 3'd4,
    ST_FINISH    = 3'd5
  } rebind_state_e;

endpackage

// File: rtl/keymap_rebind_writer_onehot_check.sv
// Combinational classifier for a key vector.
// Ports:
//   vec       in  WIDTH  vector to classify
//   is_onehot out 1      exactly one bit of vec is set
//   is_zero   out 1      no bit of vec is set
module onehot_check
  import keymap_rebind_writer_pkg::*;
#(
  parameter int WIDTH = NOTE_KEY_BITS
) (
  input  logic [WIDTH-1:0] vec,
  output logic             is_onehot,
  output logic             is_zero
);

  assign is_zero = (vec == '0);

  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  assign is_onehot = !is_zero && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/keymap_rebind_writer.sv
// Interactive write-side controller for the key-map memory.
// Walks slots 0..SLOTS-1; for each slot waits for the player to press exactly
// one unused physical key, waits for confirmation, then writes the one-hot
// mask into the key-map memory with a single-cycle strobe.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start           single-cycle pulse, begins a session (ignored while busy)
//   cancel          level, aborts the session
//   confirm         debounced level, accepts the captured key
//   keys_in         debounced physical key levels
//   wr_en/wr_addr/wr_data  memory write port (single-cycle strobe)
//   cur_slot        slot currently being prompted
//   cap_key         captured but not yet confirmed mask
//   busy            session active
//   done            pulse after the last slot is written
//   err_dup         pulse when an already-used key is pressed
//   err_timeout     pulse when a slot idles too long and the session aborts
module keymap_rebind_writer
  import keymap_rebind_writer_pkg::*;
#(
  parameter int KEY_BITS       = NOTE_KEY_BITS,
  parameter int SLOTS          = 7,
  parameter int ADDR_BITS      = 3,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cancel,
  input  logic                 confirm,
  input  logic [KEY_BITS-1:0]  keys_in,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [KEY_BITS-1:0]  wr_data,
  output logic [ADDR_BITS-1:0] cur_slot,
  output logic [KEY_BITS-1:0]  cap_key,
  output logic                 busy,
  output logic                 done,
  output logic                 err_dup,
  output logic                 err_timeout
);

  localparam int TIMER_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0]  LAST_SLOT  = ADDR_BITS'(SLOTS - 1);

  rebind_state_e         state;
  logic [KEY_BITS-1:0]   used_mask;
  logic [TIMER_BITS-1:0] timer;
  logic                  confirm_q;
  logic                  conf_rise;
  logic                  key_onehot;
  logic                  key_zero;
  logic                  key_fresh;
  logic                  in_wait;

  onehot_check #(.WIDTH(KEY_BITS)) u_onehot (
    .vec       (keys_in),
    .is_onehot (key_onehot),
    .is_zero   (key_zero)
  );

  assign key_fresh = ((keys_in & used_mask) == '0);
  assign in_wait   = (state == ST_WAIT_REL) || (state == ST_WAIT_KEY) ||
                     (state == ST_WAIT_CONF);

  // Session controller. The confirm edge is registered before the FSM sees
  // it, so a confirm edge reaches wr_en two clocks later. Abort paths are
  // checked first: cancel beats timeout, and both beat normal progress.
  // Pulse outputs default low every cycle so each is a single-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      used_mask   <= '0;
      timer       <= '0;
      confirm_q   <= 1'b0;
      conf_rise   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      cur_slot    <= '0;
      cap_key     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_dup     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      confirm_q   <= confirm;
      conf_rise   <= confirm & ~confirm_q;
      wr_en       <= 1'b0;
      done        <= 1'b0;
      err_dup     <= 1'b0;
      err_timeout <= 1'b0;

      if ((state != ST_IDLE) && cancel) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        timer   <= '0;
        cap_key <= '0;
      end else if (in_wait && (timer == TIMER_LAST)) begin
        state       <= ST_IDLE;
        busy        <= 1'b0;
        timer       <= '0;
        cap_key     <= '0;
        err_timeout <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state     <= ST_WAIT_REL;
              cur_slot  <= '0;
              used_mask <= '0;
              cap_key   <= '0;
              timer     <= '0;
              busy      <= 1'b1;
            end
          end

          // Everything must be let go first so a held key or confirm from
          // the previous slot cannot leak into this one.
          ST_WAIT_REL: begin
            if (key_zero && !confirm) begin
              state <= ST_WAIT_KEY;
              timer <= '0;
            end else begin
              timer <= timer + TIMER_BITS'(1);
            end
          end

          // Chords (more than one key) are ignored entirely.
          ST_WAIT_KEY: begin
            if (key_onehot && key_fresh) begin
              cap_key <= keys_in;
              state   <= ST_WAIT_CONF;
              timer   <= '0;
            end else if (key_onehot) begin
              err_dup <= 1'b1;
              state   <= ST_WAIT_REL;
              timer   <= '0;
            end else begin
              timer <= timer + TIMER_BITS'(1);
            end
          end

          // The player may change their mind before confirming.
          ST_WAIT_CONF: begin
            if (conf_rise) begin
              state   <= ST_WRITE;
              wr_en   <= 1'b1;
              wr_addr <= cur_slot;
              wr_data <= cap_key;
              timer   <= '0;
            end else begin
              timer <= timer + TIMER_BITS'(1);
              if (key_onehot && key_fresh) begin
                cap_key <= keys_in;
              end
            end
          end

          ST_WRITE: begin
            used_mask <= used_mask | cap_key;
            cap_key   <= '0;
            if (cur_slot == LAST_SLOT) begin
              state <= ST_FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cur_slot <= cur_slot + ADDR_BITS'(1);
              state    <= ST_WAIT_REL;
            end
          end

          ST_FINISH: begin
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keymap_rebind_writer.sv
// Self-checking bench for keymap_rebind_writer (TIMEOUT_CYCLES shortened to 16).
// Inputs are driven at the falling edge and outputs are sampled at the
// falling edge or 1 time unit after the rising edge.
module tb_keymap_rebind_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       confirm = 1'b0;
  logic [6:0] keys_in = '0;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [6:0] wr_data;
  logic [2:0] cur_slot;
  logic [6:0] cap_key;
  logic       busy;
  logic       done;
  logic       err_dup;
  logic       err_timeout;

  int checks = 0;
  int failures = 0;

  keymap_rebind_writer #(
    .KEY_BITS       (7),
    .SLOTS          (7),
    .ADDR_BITS      (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cancel      (cancel),
    .confirm     (confirm),
    .keys_in     (keys_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cur_slot    (cur_slot),
    .cap_key     (cap_key),
    .busy        (busy),
    .done        (done),
    .err_dup     (err_dup),
    .err_timeout (err_timeout)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Log every write strobe and count the other pulses so the scenarios can
  // look at deltas; also count cycles where more than one pulse is high.
  logic [2:0] wlog_addr[$];
  logic [6:0] wlog_data[$];
  int done_count = 0;
  int dup_count = 0;
  int tmo_count = 0;
  int overlap_count = 0;

  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      wlog_addr.push_back(wr_addr);
      wlog_data.push_back(wr_data);
    end
    if (done) done_count++;
    if (err_dup) dup_count++;
    if (err_timeout) tmo_count++;
    if ((int'(wr_en) + int'(done) + int'(err_dup) + int'(err_timeout)) > 1)
      overlap_count++;
  end

  typedef struct {
    logic [6:0] keys;
    logic       conf;
    logic       canc;
    logic       strt;
    int         hold;
    logic       exp_busy;
    logic [2:0] exp_slot;
    logic [6:0] exp_cap;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic [6:0] k, input logic c, input logic cn,
                                 input logic s, input int h, input logic eb,
                                 input logic [2:0] es, input logic [6:0] ec,
                                 input string n);
    vec_t v;
    v.keys = k; v.conf = c; v.canc = cn; v.strt = s; v.hold = h;
    v.exp_busy = eb; v.exp_slot = es; v.exp_cap = ec; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic [6:0] k, input logic c, input logic cn,
                               input logic s, input int hold);
    keys_in = k;
    confirm = c;
    cancel  = cn;
    start   = s;
    repeat (hold) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic runVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].keys, vecs[i].conf, vecs[i].canc, vecs[i].strt, vecs[i].hold);
      checkOutput($sformatf("%s[%0d].busy", vecs[i].name, i), 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("%s[%0d].cur_slot", vecs[i].name, i), 32'(cur_slot), 32'(vecs[i].exp_slot));
      checkOutput($sformatf("%s[%0d].cap_key", vecs[i].name, i), 32'(cap_key), 32'(vecs[i].exp_cap));
    end
    vecs.delete();
  endtask

  // Starts a session and walks it to WAIT_KEY for slot 0.
  task automatic queueStart(input string n);
    addVec(7'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 3'd0, 7'b0, {n, ".start"});
    addVec(7'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 3'd0, 7'b0, {n, ".rel"});
  endtask

  // Press a key, confirm it (edge register + WRITE), then release.
  task automatic queueSlot(input string n, input logic [6:0] k, input logic [2:0] slot,
                           input logic last);
    addVec(k,    1'b0, 1'b0, 1'b0, 1, 1'b1, slot, k, {n, ".press"});
    addVec(7'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, slot, k, {n, ".conf"});
    addVec(7'b0, 1'b0, 1'b0, 1'b0, 2, !last, last ? slot : slot + 3'd1, 7'b0, {n, ".next"});
  endtask

  task automatic cancelSession(input string n);
    applyStimulus(7'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput({n, ".cancel_busy"}, 32'(busy), 32'd0);
    applyStimulus(7'b0, 1'b0, 1'b0, 1'b0, 1);
  endtask

  initial begin
    int base_w;
    int base_done;
    int base_dup;
    int base_tmo;
    int seen_at;
    logic [6:0] k;

    // Reset state while rst_n is held low.
    #3;
    checkOutput("reset.pulses", 32'({wr_en, busy, done, err_dup, err_timeout}), 32'd0);
    checkOutput("reset.cur_slot", 32'(cur_slot), 32'd0);
    checkOutput("reset.cap_key", 32'(cap_key), 32'd0);
    checkOutput("reset.wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset.wr_data", 32'(wr_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full seven-slot session, slot i bound to 1<<(6-i).
    $display("[TB] full session");
    base_w = wlog_addr.size();
    base_done = done_count;
    queueStart("full");
    for (int i = 0; i < 7; i++) begin
      k = 7'b1 << (6 - i);
      queueSlot("full", k, 3'(i), i == 6);
    end
    runVectors();
    checkOutput("full.write_count", 32'(wlog_addr.size() - base_w), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (base_w + i < wlog_addr.size()) begin
        k = 7'b1 << (6 - i);
        checkOutput($sformatf("full.wr_addr%0d", i), 32'(wlog_addr[base_w + i]), 32'(i));
        checkOutput($sformatf("full.wr_data%0d", i), 32'(wlog_data[base_w + i]), 32'(k));
      end
    end
    checkOutput("full.done_count", 32'(done_count - base_done), 32'd1);

    // Duplicate key on slot 1.
    $display("[TB] duplicate key");
    base_w = wlog_addr.size();
    base_dup = dup_count;
    queueStart("dup");
    queueSlot("dup.s0", 7'b0000001, 3'd0, 1'b0);
    runVectors();
    applyStimulus(7'b0000001, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("dup.err_dup_high", 32'(err_dup), 32'd1);
    applyStimulus(7'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("dup.err_dup_low", 32'(err_dup), 32'd0);
    checkOutput("dup.cur_slot", 32'(cur_slot), 32'd1);
    checkOutput("dup.no_write", 32'(wlog_addr.size() - base_w), 32'd1);
    queueSlot("dup.s1", 7'b0000100, 3'd1, 1'b0);
    runVectors();
    checkOutput("dup.dup_count", 32'(dup_count - base_dup), 32'd1);
    checkOutput("dup.write_count", 32'(wlog_addr.size() - base_w), 32'd2);
    if (base_w + 1 < wlog_addr.size()) begin
      checkOutput("dup.wr_addr1", 32'(wlog_addr[base_w + 1]), 32'd1);
      checkOutput("dup.wr_data1", 32'(wlog_data[base_w + 1]), 32'h04);
    end
    cancelSession("dup");

    // Chord of two keys is never captured, so confirm does nothing.
    $display("[TB] multi-key");
    base_w = wlog_addr.size();
    queueStart("multi");
    addVec(7'b0000011, 1'b0, 1'b0, 1'b0, 2, 1'b1, 3'd0, 7'b0, "multi.chord");
    addVec(7'b0000011, 1'b1, 1'b0, 1'b0, 3, 1'b1, 3'd0, 7'b0, "multi.conf");
    addVec(7'b0,       1'b0, 1'b0, 1'b0, 1, 1'b1, 3'd0, 7'b0, "multi.rel");
    runVectors();
    checkOutput("multi.no_write", 32'(wlog_addr.size() - base_w), 32'd0);
    cancelSession("multi");

    // Re-capture a different key before confirming.
    $display("[TB] re-capture");
    base_w = wlog_addr.size();
    queueStart("recap");
    addVec(7'b0001000, 1'b0, 1'b0, 1'b0, 1, 1'b1, 3'd0, 7'b0001000, "recap.first");
    addVec(7'b0,       1'b0, 1'b0, 1'b0, 1, 1'b1, 3'd0, 7'b0001000, "recap.rel");
    queueSlot("recap", 7'b0010000, 3'd0, 1'b0);
    runVectors();
    checkOutput("recap.write_count", 32'(wlog_addr.size() - base_w), 32'd1);
    if (base_w < wlog_addr.size()) begin
      checkOutput("recap.wr_addr", 32'(wlog_addr[base_w]), 32'd0);
      checkOutput("recap.wr_data", 32'(wlog_data[base_w]), 32'h10);
    end
    cancelSession("recap");

    // Timeout: no key after start. One clock in WAIT_REL, then 16 counted
    // clocks in WAIT_KEY, so the pulse appears 16 or 17 clocks after start.
    $display("[TB] timeout");
    base_w = wlog_addr.size();
    base_tmo = tmo_count;
    seen_at = 0;
    applyStimulus(7'b0, 1'b0, 1'b0, 1'b1, 1);
    applyStimulus(7'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (err_timeout) begin
        seen_at = c;
        break;
      end
    end
    checkOutput("timeout.cycle_in_window", 32'(seen_at >= 16 && seen_at <= 17), 32'd1);
    checkOutput("timeout.busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("timeout.pulse_count", 32'(tmo_count - base_tmo), 32'd1);
    checkOutput("timeout.no_write", 32'(wlog_addr.size() - base_w), 32'd0);

    // Cancel and confirm together in WAIT_CONF: cancel wins.
    $display("[TB] cancel vs confirm");
    base_w = wlog_addr.size();
    base_done = done_count;
    queueStart("canc");
    addVec(7'b0100000, 1'b0, 1'b0, 1'b0, 1, 1'b1, 3'd0, 7'b0100000, "canc.press");
    addVec(7'b0,       1'b1, 1'b1, 1'b0, 1, 1'b0, 3'd0, 7'b0,       "canc.both");
    addVec(7'b0,       1'b0, 1'b0, 1'b0, 3, 1'b0, 3'd0, 7'b0,       "canc.idle");
    runVectors();
    checkOutput("canc.no_write", 32'(wlog_addr.size() - base_w), 32'd0);
    checkOutput("canc.no_done", 32'(done_count - base_done), 32'd0);

    // Reset asserted while the write strobe is high.
    $display("[TB] reset mid-write");
    queueStart("rstw");
    addVec(7'b0000010, 1'b0, 1'b0, 1'b0, 1, 1'b1, 3'd0, 7'b0000010, "rstw.press");
    addVec(7'b0,       1'b1, 1'b0, 1'b0, 2, 1'b1, 3'd0, 7'b0000010, "rstw.conf");
    runVectors();
    checkOutput("rstw.wr_en_before", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstw.wr_en_after", 32'(wr_en), 32'd0);
    checkOutput("rstw.pulses", 32'({busy, done, err_dup, err_timeout}), 32'd0);
    checkOutput("rstw.cap_key", 32'(cap_key), 32'd0);
    checkOutput("rstw.wr_data", 32'(wr_data), 32'd0);
    confirm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("pulse_overlap", 32'(overlap_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keymap_rebind_writer.md
Name: keymap_rebind_writer

Overview:
- Interactive write-side controller for the key-map memory (note-key map: slot index -> one-hot physical key mask).
- Walks logical slots 0..SLOTS-1 in order. For each slot it waits for the player to press exactly one physical key, then waits for confirmation, then issues a single-cycle write to the memory.
- Sits between the debounced board switches and the key-map memory's write port. Driven by the menu/top-level FSM through start/cancel.

Parameters:
- KEY_BITS, 7, width of physical key vector and of each stored one-hot mask (matches note-key width constant).
- SLOTS, 7, number of logical slots to rebind; must be <= 2**ADDR_BITS.
- ADDR_BITS, 3, width of slot index / write address.
- TIMEOUT_CYCLES, 500_000_000, idle cycles allowed per slot before abort (5 s at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a rebind session.
- cancel  in  1  level; aborts the session.
- confirm  in  1  debounced level; accepts the captured key.
- keys_in  in  KEY_BITS  debounced physical key levels, synchronous to clk.
- wr_en  out  1  single-cycle memory write strobe.
- wr_addr  out  ADDR_BITS  slot index being written.
- wr_data  out  KEY_BITS  one-hot mask written.
- cur_slot  out  ADDR_BITS  slot currently being prompted (for display).
- cap_key  out  KEY_BITS  captured, not yet confirmed, mask (for display).
- busy  out  1  high while the session is active.
- done  out  1  single-cycle pulse after the last slot is written.
- err_dup  out  1  single-cycle pulse when a key already used in this session is pressed.
- err_timeout  out  1  single-cycle pulse on timeout abort.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0. used_mask=0, timer=0, cap_key=0.
- States: IDLE, WAIT_REL, WAIT_KEY, WAIT_CONF, WRITE, FINISH.
- IDLE: start=1 -> cur_slot=0, used_mask=0, timer=0, go to WAIT_REL. busy is 1 from the next cycle.
- WAIT_REL: stays until keys_in==0 and confirm==0, then goes to WAIT_KEY. This prevents carry-over presses.
- WAIT_KEY:
  - keys_in==0: keep waiting.
  - keys_in one-hot and (keys_in & used_mask)==0: cap_key<=keys_in, go to WAIT_CONF.
  - keys_in one-hot but already used: err_dup pulses one cycle, go to WAIT_REL.
  - keys_in with >1 bit set: ignored, no capture.
- WAIT_CONF:
  - confirm rising edge (edge detector inside the block): go to WRITE.
  - A different one-hot, unused key pressed: re-capture it into cap_key.
- WRITE: exactly one cycle. wr_en=1, wr_addr=cur_slot, wr_data=cap_key. used_mask|=cap_key.
  - If cur_slot==SLOTS-1, go to FINISH.
  - Otherwise cur_slot+1, cap_key=0, go to WAIT_REL.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Timer: counts in WAIT_REL, WAIT_KEY and WAIT_CONF; cleared on every state change. When it reaches TIMEOUT_CYCLES-1: err_timeout pulses, go to IDLE, no write.
- cancel=1 in any non-IDLE state: go to IDLE next cycle with no write and no done. Cancel has priority over confirm and timeout in the same cycle.
- Slots already written before an abort stay written. There is no rollback.
- start while busy is ignored.
- wr_en, done and the err_* outputs are registered outputs, never asserted together.
- Latency: confirm edge -> wr_en takes 2 cycles (edge detect + WRITE).
- rst_n asserted mid-session: immediate return to IDLE; wr_en drops asynchronously.

Decomposition:
- Shared constants header: NOTE_KEY_BITS (=7), LENGTH_KEY_BITS, and the state encodings.
- One natural sub-module: onehot_check (combinational). Outputs is_onehot and is_zero for a KEY_BITS vector; can be reused by the playback decoder.
- The confirm edge detector stays inline.

Test Plan:
- Full session, SLOTS=7: start; for slot i press keys_in=7'b1<<(6-i), release, pulse confirm -> seven wr_en pulses with (addr i, data 1<<(6-i)), then done pulse; busy low afterwards.
- Duplicate: slot0 bound to 7'b0000001; at slot1 press 7'b0000001 -> err_dup pulses once, no wr_en, cur_slot stays 1; then 7'b0000100 plus confirm -> write (1, 7'b0000100).
- Multi-key: at slot0 press 7'b0000011 -> no capture, cap_key=0; confirm -> no write.
- Re-capture: press 7'b0001000, release, press 7'b0010000, confirm -> write (0, 7'b0010000).
- Timeout, TIMEOUT_CYCLES=16: start, no keys for 16 cycles -> err_timeout pulse on cycle 16, busy=0, no wr_en.
- Cancel/reset: cancel and confirm in the same cycle during WAIT_CONF -> no write, IDLE. Separately, drop rst_n mid-WRITE -> wr_en=0 immediately and all outputs 0.
